ro_pair_freq_compare: RTL and testbench
=======================================

// Module: ro_pair_freq_compare
// PURPOSE
//  Downstream stage of the two mux_16to1 ring-oscillator selectors in the RO-PUF datapath.
//  Drives the select lines of both muxes from a challenge pair.
//  Counts rising edges of the two selected RO outputs over a fixed clk window.
//  Compares the counts and emits one response bit per challenge, with count readback for characterisation.
// PARAMETERS
//  SEL_W       4     select width per mux (16 ROs per bank)
//  CNT_W       16    edge-counter width; counters saturate at 2**CNT_W-1
//  WINDOW      1024  clk cycles in the COUNT state (>=1)
//  SETTLE_CYC  4     clk cycles after a select change before counting (>=1; covers mux + sync settle)
//  SYNC_STAGES 2     synchroniser flops per RO input (>=2)
// PORTS
//  clk          in   1      single system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      request evaluation; sampled only in IDLE
//  challenge_a  in   SEL_W  RO index for bank A
//  challenge_b  in   SEL_W  RO index for bank B
//  sel_a        out  SEL_W  to mux_16to1 bank A sel
//  sel_b        out  SEL_W  to mux_16to1 bank B sel
//  ro_a         in   1      bank A mux output (asynchronous to clk)
//  ro_b         in   1      bank B mux output (asynchronous to clk)
//  busy         out  1      high in every state except IDLE
//  valid        out  1      one-cycle pulse; response/tie/counts are valid
//  response     out  1      1 iff count_a > count_b
//  tie          out  1      1 iff count_a == count_b
//  count_a      out  CNT_W  bank A edges in last window; held until the next valid
//  count_b      out  CNT_W  bank B edges in last window; held until the next valid
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all outputs 0.
//  FSM:
//   - IDLE:    start=1 -> latch challenge_a/b into sel_a/sel_b, clear both counters, go to SETTLE.
//   - SETTLE:  exactly SETTLE_CYC cycles, no counting, then go to COUNT.
//   - COUNT:   exactly WINDOW cycles, counting, then go to DONE.
//   - DONE:    one cycle, then go to IDLE.
//  Latency: start sampled at edge k -> valid high for the cycle after edge k+SETTLE_CYC+WINDOW+1.
//  Outputs at DONE: response, tie, count_a, count_b registered together with the valid pulse.
//  Edge detect: ro_x -> SYNC_STAGES flops -> rising edge = sync & ~sync_d.
//   - Increment only while state==COUNT.
//   - Saturate at all-ones, never wrap.
//   - Per-window edge-count uncertainty is +/-1 (sync boundary); this is inherent and accepted.
//  sel_a/sel_b: held from latch until the next accepted start; no change while busy.
//  start while busy: ignored (no queueing).
//  start held high through DONE: the cycle after DONE is IDLE, so a new run begins then (back-to-back allowed).
//  challenge_a==challenge_b: legal; normally yields tie=1, response=0.
//  Both counts saturated: tie=1, response=0.
//  rst_n low mid-run: immediate IDLE, counters cleared, outputs 0; no valid pulse.
//  RO frequency must be < clk/2 for exact counting; above that, undercount is acceptable (not a fault).
// STRUCTURE
//  puf_pkg holds:
//   - SEL_W, N_RO=16
//   - typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} cmp_state_t
//   - typedef logic [SEL_W-1:0] ro_sel_t
//  Sub-module ro_edge_counter (sync chain + edge detect + saturating counter, en/clr inputs), instantiated twice.
//  Top-level holds the FSM, window/settle counter, select registers and output registers.
// TESTING (WINDOW=64, SETTLE_CYC=4, CNT_W=8, clk 10ns)
//  1. Reset: rst_n=0 with start=1 -> all outputs 0, busy 0; release -> IDLE, nothing until next start.
//  2. chal a=3/b=12; ro_a period 40ns, ro_b period 80ns
//     -> sel_a=3, sel_b=12 the cycle after start; valid at cycle 69 after start.
//     -> count_a in 15..17, count_b in 7..9, response=1, tie=0.
//  3. Swap frequencies -> response=0, tie=0. Identical waveforms on both inputs -> tie=1, response=0.
//  4. Pulse start 10 cycles into COUNT with different challenge -> ignored; sel unchanged; one valid only.
//  5. rst_n low 20 cycles into COUNT -> busy/sel/counts 0 immediately, no valid; restart gives a correct result.
//  6. CNT_W=4 with ro_a period 40ns -> count_a=15 (saturated), no wrap.
//     Hold start high -> two valids, (SETTLE_CYC+WINDOW+2) cycles apart.

Source files
------------

// File: rtl/ro_pair_freq_compare_pkg.sv
// Shared types and constants for the RO-PUF pair comparator: state encoding and
// the mux select type.
package ro_pair_freq_compare_pkg;

  localparam int SEL_W = 4;
  localparam int N_RO  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } cmp_state_t;

  typedef logic [SEL_W-1:0] ro_sel_t;

  // Response bit: bank A wins only on a strictly larger count.
  function automatic logic a_wins(input logic [31:0] cnt_a, input logic [31:0] cnt_b);
    return (cnt_a > cnt_b);
  endfunction

endpackage

// File: rtl/ro_pair_freq_compare_ro_edge_counter.sv
// Synchronises one asynchronous RO output, detects its rising edges and counts
// them while enabled, saturating at all-ones.
module ro_edge_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   rise_s;

  assign rise_s  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign count_o = cnt_q;

  // Next count: clear wins, otherwise increment on an edge unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_ZERO;
    end else if (en_i && rise_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Synchroniser chain, edge-detect history and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
      cnt_q  <= CNT_ZERO;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ro_pair_freq_compare.sv
// Drives the two RO mux selects from a challenge, counts both selected ROs over a
// fixed window and reports which one ran faster, plus the raw counts.
module ro_pair_freq_compare
  import ro_pair_freq_compare_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int WINDOW      = 1024,
  parameter int SETTLE_CYC  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  ro_sel_t          challenge_a_i,
  input  ro_sel_t          challenge_b_i,
  output ro_sel_t          sel_a_o,
  output ro_sel_t          sel_b_o,
  input  logic             ro_a_i,
  input  logic             ro_b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic             response_o,
  output logic             tie_o,
  output logic [CNT_W-1:0] count_a_o,
  output logic [CNT_W-1:0] count_b_o
);

  localparam int TMR_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE   = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);

  cmp_state_t       state_q;
  logic [TMR_W-1:0] timer_q;
  ro_sel_t          sel_a_q;
  ro_sel_t          sel_b_q;
  logic             busy_q;
  logic             valid_q;
  logic             response_q;
  logic             tie_q;
  logic [CNT_W-1:0] count_a_q;
  logic [CNT_W-1:0] count_b_q;

  logic             accept_s;
  logic             count_en_s;
  logic [CNT_W-1:0] cnt_a_s;
  logic [CNT_W-1:0] cnt_b_s;

  assign accept_s   = (state_q == IDLE) && start_i;
  assign count_en_s = (state_q == COUNT);

  ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .ro_i    (ro_a_i),
    .en_i    (count_en_s),
    .clr_i   (accept_s),
    .count_o (cnt_a_s)
  );

  ro_edge_counter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .ro_i    (ro_b_i),
    .en_i    (count_en_s),
    .clr_i   (accept_s),
    .count_o (cnt_b_s)
  );

  // Evaluation sequencer; the timer is reloaded on entry to each timed state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= TMR_ZERO;
      sel_a_q    <= {SEL_W{1'b0}};
      sel_b_q    <= {SEL_W{1'b0}};
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      response_q <= 1'b0;
      tie_q      <= 1'b0;
      count_a_q  <= {CNT_W{1'b0}};
      count_b_q  <= {CNT_W{1'b0}};
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sel_a_q <= challenge_a_i;
            sel_b_q <= challenge_b_i;
            timer_q <= SETTLE_LD;
            busy_q  <= 1'b1;
            state_q <= SETTLE;
          end else begin
            state_q <= IDLE;
          end
        end
        SETTLE: begin
          if (timer_q == TMR_ZERO) begin
            timer_q <= WINDOW_LD;
            state_q <= COUNT;
          end else begin
            timer_q <= timer_q - TMR_ONE;
          end
        end
        COUNT: begin
          if (timer_q == TMR_ZERO) begin
            state_q <= DONE;
          end else begin
            timer_q <= timer_q - TMR_ONE;
          end
        end
        DONE: begin
          // Counters are frozen here, so the final counts are captured with valid.
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          valid_q    <= 1'b1;
          response_q <= a_wins(32'(cnt_a_s), 32'(cnt_b_s));
          tie_q      <= (cnt_a_s == cnt_b_s);
          count_a_q  <= cnt_a_s;
          count_b_q  <= cnt_b_s;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel_a_o    = sel_a_q;
  assign sel_b_o    = sel_b_q;
  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign response_o = response_q;
  assign tie_o      = tie_q;
  assign count_a_o  = count_a_q;
  assign count_b_o  = count_b_q;

endmodule

// File: tb/tb_ro_pair_freq_compare.sv
// Randomised self-checking bench for ro_pair_freq_compare with ideal RO waveform
// generators and an edge-count model derived from the RO periods.
module tb_ro_pair_freq_compare;

  localparam int WINDOW = 64;
  localparam int SETTLE = 4;
  localparam int LAT    = SETTLE + WINDOW + 1;
  localparam int CLK_NS = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] ch_a = 4'd0;
  logic [3:0] ch_b = 4'd0;
  logic       ro_a_gen = 1'b0;
  logic       ro_b_gen = 1'b0;
  logic       same_wave = 1'b0;
  int         half_a = 20;
  int         half_b = 40;
  wire        ro_a = ro_a_gen;
  wire        ro_b = same_wave ? ro_a_gen : ro_b_gen;

  logic [3:0] sel_a, sel_b, s4_sel_a, s4_sel_b;
  logic       busy, valid, response, tie;
  logic       s4_busy, s4_valid, s4_response, s4_tie;
  logic [7:0] cnt_a, cnt_b;
  logic [3:0] s4_cnt_a, s4_cnt_b;

  int total = 0;
  int bad   = 0;

  ro_pair_freq_compare #(.CNT_W(8), .WINDOW(WINDOW), .SETTLE_CYC(SETTLE), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .challenge_a_i(ch_a), .challenge_b_i(ch_b),
    .sel_a_o(sel_a), .sel_b_o(sel_b), .ro_a_i(ro_a), .ro_b_i(ro_b), .busy_o(busy),
    .valid_o(valid), .response_o(response), .tie_o(tie), .count_a_o(cnt_a), .count_b_o(cnt_b)
  );

  ro_pair_freq_compare #(.CNT_W(4), .WINDOW(WINDOW), .SETTLE_CYC(SETTLE), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_i(start), .challenge_a_i(ch_a), .challenge_b_i(ch_b),
    .sel_a_o(s4_sel_a), .sel_b_o(s4_sel_b), .ro_a_i(ro_a), .ro_b_i(ro_b), .busy_o(s4_busy),
    .valid_o(s4_valid), .response_o(s4_response), .tie_o(s4_tie), .count_a_o(s4_cnt_a),
    .count_b_o(s4_cnt_b)
  );

  always #5 clk = ~clk;
  initial begin #2; forever begin #(half_a) ro_a_gen = ~ro_a_gen; end end
  initial begin #3; forever begin #(half_b) ro_b_gen = ~ro_b_gen; end end

  // Ideal number of rising edges of a square wave with the given half period in one window.
  function automatic int nominal(input int half);
    return (WINDOW * CLK_NS) / (2 * half);
  endfunction

  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    start = 1'b1; ch_a = a; ch_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, valid, response, tie, sel_a, sel_b, cnt_a, cnt_b} !== 28'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {busy, valid, response, tie, sel_a, sel_b, cnt_a, cnt_b});
    end
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        bad++; $display("FAIL reset_idle busy=%b valid=%b want 0/0", busy, valid);
      end
    end
  endtask

  task automatic run_check(input string name, input logic [3:0] a, input logic [3:0] b,
                           input int ha, input int hb, input logic same);
    int cyc, lo_a, hi_a, lo_b, hi_b;
    logic exp_resp, exp_tie;
    half_a = ha; half_b = hb; same_wave = same;
    launch(a, b);
    total++;
    if (sel_a !== a || sel_b !== b || busy !== 1'b1) begin
      bad++; $display("FAIL %s_sel got=%0d/%0d busy=%b want=%0d/%0d busy=1", name, sel_a, sel_b, busy, a, b);
    end
    wait_valid(cyc);
    total++;
    if (cyc !== LAT) begin
      bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, LAT);
    end
    lo_a = nominal(ha) - 1; hi_a = nominal(ha) + 1;
    lo_b = same ? lo_a : nominal(hb) - 1; hi_b = same ? hi_a : nominal(hb) + 1;
    exp_tie  = same;
    exp_resp = !same && (ha < hb);
    total++;
    if (!(int'(cnt_a) >= lo_a && int'(cnt_a) <= hi_a && int'(cnt_b) >= lo_b && int'(cnt_b) <= hi_b)) begin
      bad++; $display("FAIL %s_counts got=%0d/%0d want %0d..%0d/%0d..%0d", name, cnt_a, cnt_b, lo_a, hi_a, lo_b, hi_b);
    end
    total++;
    if (response !== exp_resp || tie !== exp_tie) begin
      bad++; $display("FAIL %s_result got resp=%b tie=%b want resp=%b tie=%b", name, response, tie, exp_resp, exp_tie);
    end
    @(posedge clk); #1;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0 || sel_a !== a) begin
      bad++; $display("FAIL %s_after got valid=%b busy=%b sel_a=%0d want 0/0/%0d", name, valid, busy, sel_a, a);
    end
  endtask

  task automatic test_basic;
    run_check("basic", 4'd3, 4'd12, 20, 40, 1'b0);
  endtask

  task automatic test_swap_and_tie;
    run_check("swap", 4'd5, 4'd6, 40, 20, 1'b0);
    run_check("same", 4'd7, 4'd7, 40, 40, 1'b1);
    same_wave = 1'b0;
  endtask

  task automatic test_start_while_busy;
    int cyc, extra;
    half_a = 20; half_b = 80; same_wave = 1'b0;
    launch(4'd1, 4'd2);
    repeat (SETTLE + 10) @(posedge clk);
    @(negedge clk); start = 1'b1; ch_a = 4'd9; ch_b = 4'd10;
    @(posedge clk); #1; start = 1'b0;
    total++;
    if (sel_a !== 4'd1 || sel_b !== 4'd2) begin
      bad++; $display("FAIL busy_start_sel got=%0d/%0d want=1/2", sel_a, sel_b);
    end
    wait_valid(cyc);
    total++;
    if (cyc !== LAT - SETTLE - 11) begin
      bad++; $display("FAIL busy_start_latency got=%0d want=%0d", cyc, LAT - SETTLE - 11);
    end
    total++;
    if (response !== 1'b1 || tie !== 1'b0) begin
      bad++; $display("FAIL busy_start_result got resp=%b tie=%b want 1/0", response, tie);
    end
    extra = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (valid) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++; $display("FAIL busy_start_extra_valid got=%0d want=0", extra);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    half_a = 20; half_b = 40; same_wave = 1'b0;
    launch(4'd4, 4'd11);
    repeat (SETTLE + 20) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    total++;
    if ({busy, valid, sel_a, sel_b, cnt_a, cnt_b} !== 26'd0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0", {busy, valid, sel_a, sel_b, cnt_a, cnt_b});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (valid || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL midreset_quiet got=%0d active cycles want=0", seen);
    end
    run_check("restart", 4'd4, 4'd11, 20, 40, 1'b0);
  endtask

  task automatic test_random;
    int halves [3] = '{20, 40, 80};
    int ia, ib;
    for (int n = 0; n < 6; n++) begin
      ia = $urandom_range(0, 2);
      ib = $urandom_range(0, 2);
      run_check("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                halves[ia], halves[ib], ia == ib);
    end
    same_wave = 1'b0;
  endtask

  task automatic test_back_to_back;
    int cyc, nvalid, first_cyc, second_cyc;
    half_a = 20; half_b = 40; same_wave = 1'b0;
    nvalid = 0; first_cyc = 0; second_cyc = 0; cyc = 0;
    @(negedge clk); start = 1'b1; ch_a = 4'd0; ch_b = 4'd15;
    while (nvalid < 2 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (s4_valid) begin
        nvalid++;
        if (nvalid == 1) first_cyc = cyc; else second_cyc = cyc;
        total++;
        if (s4_cnt_a !== 4'd15 || s4_tie !== 1'b0 || s4_response !== 1'b1) begin
          bad++; $display("FAIL sat_count got=%0d tie=%b resp=%b want=15/0/1", s4_cnt_a, s4_tie, s4_response);
        end
        total++;
        if (!(cnt_a >= 8'd15 && cnt_a <= 8'd17)) begin
          bad++; $display("FAIL b2b_wide_count got=%0d want 15..17", cnt_a);
        end
      end
    end
    start = 1'b0;
    total++;
    if (nvalid !== 2 || second_cyc - first_cyc !== SETTLE + WINDOW + 2) begin
      bad++; $display("FAIL b2b_spacing got n=%0d gap=%0d want n=2 gap=%0d", nvalid, second_cyc - first_cyc, SETTLE + WINDOW + 2);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || s4_busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got busy=%b/%b want 0/0", busy, s4_busy);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_swap_and_tie;
    test_start_while_busy;
    test_reset_mid_run;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
